// File: rtl/slice_header_gen_pkg.sv
// Shared types and constants for the slice header generator: FSM states,
// header field widths and the header-byte count as a function of component count.
package slice_header_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HSIZE,
      ST_RSV,
      ST_QS,
      ST_CSIZE,
      ST_DONE
   } state_t;

   localparam int W_HSIZE = 5;
   localparam int W_RSV   = 3;
   localparam int W_QS    = 8;
   localparam int W_CSIZE = 16;

   // Header bytes: two fixed bytes plus one 16-bit size per emitted component.
   function automatic int unsigned header_bytes(input int unsigned num_comp);
      return 2 + 2 * (num_comp - 1);
   endfunction

endpackage

// File: rtl/slice_header_gen_if.sv
// Request/field handshake bundle between a header requester/bit-writer and the
// slice header generator.
interface slice_header_gen_if #(
   parameter int NUM_COMP = 3
);
   logic                     start;
   logic [7:0]               qscale;
   logic [NUM_COMP*16-1:0]   comp_size;
   logic                     out_ready;
   logic                     output_enable;
   logic [63:0]              val;
   logic [63:0]              size_of_bit;
   logic                     flush_bit;
   logic                     busy;
   logic                     done;

   modport master (
      output start, qscale, comp_size, out_ready,
      input  output_enable, val, size_of_bit, flush_bit, busy, done
   );

   modport slave (
      input  start, qscale, comp_size, out_ready,
      output output_enable, val, size_of_bit, flush_bit, busy, done
   );
endinterface

// File: rtl/slice_header_gen.sv
// Emits a slice header as a sequence of registered (value, width) fields to a
// bit-writer with a valid/ready handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; captures qscale/comp_size on start
// ST_HSIZE | header-size field (header bytes, 5 bits)
// ST_RSV   | reserved field (0, 3 bits)
// ST_QS    | clamped qscale field (8 bits)
// ST_CSIZE | component size fields idx=0..NUM_COMP-2 (16 bits each)
// ST_DONE  | one-cycle done pulse, then back to idle
module slice_header_gen
   import slice_header_gen_pkg::*;
#(
   parameter int NUM_COMP     = 3,
   parameter int MAX_QSCALE   = 224,
   parameter bit FLUSH_AT_END = 1'b0
) (
   input  logic               clock,
   input  logic               reset,
   slice_header_gen_if.slave  bus
);

   localparam logic [1:0]  LAST_IDX  = 2'(NUM_COMP - 2);
   localparam logic [7:0]  QS_MAX    = 8'(MAX_QSCALE);
   localparam logic [63:0] HDR_BYTES = 64'(header_bytes(NUM_COMP));

   state_t                 state, next_state;
   logic [1:0]             idx, next_idx;
   logic [7:0]             qscale_q;
   logic [NUM_COMP*16-1:0] comp_size_q;
   logic                   oe_q, flush_q;
   logic [63:0]            val_q, sob_q;
   logic                   accept, field_en, field_flush;
   logic [63:0]            field_val, field_sob;

   function automatic logic [7:0] clamp_qs(input logic [7:0] q);
      if (q == 8'd0)
         return 8'd1;
      if (q > QS_MAX)
         return QS_MAX;
      return q;
   endfunction

   always_comb begin
      accept      = oe_q && bus.out_ready;
      next_state  = state;
      next_idx    = idx;
      field_en    = 1'b0;
      field_val   = '0;
      field_sob   = '0;
      field_flush = 1'b0;

      case (state)
         ST_IDLE:  if (bus.start) begin
                      next_state = ST_HSIZE;
                      next_idx   = '0;
                   end
         ST_HSIZE: if (accept) next_state = ST_RSV;
         ST_RSV:   if (accept) next_state = ST_QS;
         ST_QS:    if (accept) begin
                      next_state = ST_CSIZE;
                      next_idx   = '0;
                   end
         ST_CSIZE: if (accept) begin
                      if (idx == LAST_IDX) next_state = ST_DONE;
                      else                 next_idx   = idx + 2'd1;
                   end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase

      // The output register is loaded with the field of the upcoming state, so an
      // accepted field is replaced in the very next cycle; the capture cycle
      // out of idle deliberately presents nothing.
      if (state != ST_IDLE) begin
         case (next_state)
            ST_HSIZE: begin
               field_en  = 1'b1;
               field_val = HDR_BYTES;
               field_sob = 64'(W_HSIZE);
            end
            ST_RSV: begin
               field_en  = 1'b1;
               field_sob = 64'(W_RSV);
            end
            ST_QS: begin
               field_en  = 1'b1;
               field_val = 64'(clamp_qs(qscale_q));
               field_sob = 64'(W_QS);
            end
            ST_CSIZE: begin
               field_en    = 1'b1;
               field_val   = 64'(comp_size_q[16*next_idx +: 16]);
               field_sob   = 64'(W_CSIZE);
               field_flush = FLUSH_AT_END && (next_idx == LAST_IDX);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         qscale_q    <= '0;
         comp_size_q <= '0;
         oe_q        <= 1'b0;
         val_q       <= '0;
         sob_q       <= '0;
         flush_q     <= 1'b0;
      end else begin
         state   <= next_state;
         idx     <= next_idx;
         oe_q    <= field_en;
         val_q   <= field_val;
         sob_q   <= field_sob;
         flush_q <= field_flush;
         if (state == ST_IDLE && bus.start) begin
            qscale_q    <= bus.qscale;
            comp_size_q <= bus.comp_size;
         end
      end
   end

   assign bus.output_enable = oe_q;
   assign bus.val           = val_q;
   assign bus.size_of_bit   = sob_q;
   assign bus.flush_bit     = flush_q;
   assign bus.busy          = (state == ST_HSIZE) || (state == ST_RSV) ||
                              (state == ST_QS)    || (state == ST_CSIZE);
   assign bus.done          = (state == ST_DONE);

endmodule

// File: tb/tb_slice_header_gen.sv
// Directed bench for slice_header_gen: a 3-component instance driven from a
// vector table, and a 4-component flushing instance plus reset corner cases.
module tb_slice_header_gen;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   slice_header_gen_if #(.NUM_COMP(3)) ifa ();
   slice_header_gen_if #(.NUM_COMP(4)) ifb ();

   slice_header_gen #(.NUM_COMP(3)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (ifa.slave)
   );

   slice_header_gen #(.NUM_COMP(4), .FLUSH_AT_END(1'b1)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (ifb.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  qs;
      logic [47:0] sizes;
      bit          rand_ready;
      bit          disturb;
      logic [7:0]  exp_qs;
   } vec_t;

   vec_t vecs[6];

   task automatic run_a(input vec_t v);
      logic [63:0] ev[5];
      logic [63:0] es[5];
      logic [63:0] pv, ps;
      bit          held, rdy;
      int          got, cyc;
      ev = '{64'd6, 64'd0, 64'(v.exp_qs), 64'(v.sizes[15:0]), 64'(v.sizes[31:16])};
      es = '{64'd5, 64'd3, 64'd8, 64'd16, 64'd16};
      pv = '0; ps = '0; held = 1'b0; got = 0;

      @(negedge clock);
      ifa.start     = 1'b1;
      ifa.qscale    = v.qs;
      ifa.comp_size = v.sizes;
      ifa.out_ready = 1'b1;
      @(negedge clock);
      cyc = 1;
      if (!v.disturb) ifa.start = 1'b0;
      check("capture_busy", 64'(ifa.busy), 64'd1);
      check("capture_oe", 64'(ifa.output_enable), 64'd0);
      check("capture_val", ifa.val, 64'd0);

      while (got < 5 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (v.disturb) begin
            ifa.start     = 1'b1;
            ifa.qscale    = 8'($urandom);
            ifa.comp_size = 48'({$urandom, $urandom});
         end
         rdy = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         ifa.out_ready = rdy;
         if (ifa.output_enable) begin
            if (held) begin
               check("held_val", ifa.val, pv);
               check("held_size", ifa.size_of_bit, ps);
            end
            if (rdy) begin
               check("field_val", ifa.val, ev[got]);
               check("field_size", ifa.size_of_bit, es[got]);
               check("field_flush", 64'(ifa.flush_bit), 64'd0);
               if (!v.rand_ready) check("field_cycle", 64'(cyc), 64'(got + 2));
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               pv   = ifa.val;
               ps   = ifa.size_of_bit;
            end
         end
      end
      if (got < 5) check("field_timeout", 64'(got), 64'd5);
      ifa.start = 1'b0;

      @(negedge clock);
      check("done_pulse", 64'(ifa.done), 64'd1);
      check("done_busy", 64'(ifa.busy), 64'd0);
      check("done_oe", 64'(ifa.output_enable), 64'd0);
      @(negedge clock);
      check("done_clear", 64'(ifa.done), 64'd0);
      check("idle_busy", 64'(ifa.busy), 64'd0);
   endtask

   initial begin
      logic [63:0] bv[6];
      logic [63:0] bs[6];
      logic [63:0] bf[6];
      bit found;

      reset = 1'b1;
      ifa.start = 1'b0; ifa.qscale = '0; ifa.comp_size = '0; ifa.out_ready = 1'b0;
      ifb.start = 1'b0; ifb.qscale = '0; ifb.comp_size = '0; ifb.out_ready = 1'b0;

      vecs[0] = '{8'd8,   {16'h0050, 16'h007c, 16'h0319}, 1'b0, 1'b0, 8'd8};
      vecs[1] = '{8'd0,   {16'h1111, 16'h2222, 16'h3333}, 1'b0, 1'b0, 8'd1};
      vecs[2] = '{8'd255, {16'hffff, 16'h8001, 16'h0001}, 1'b1, 1'b0, 8'd224};
      vecs[3] = '{8'd224, {16'h0000, 16'habcd, 16'h1234}, 1'b1, 1'b1, 8'd224};
      vecs[4] = '{8'd1,   {16'h0404, 16'h0303, 16'h0202}, 1'b0, 1'b1, 8'd1};
      vecs[5] = '{8'd225, {16'h7777, 16'h5555, 16'h6666}, 1'b1, 1'b0, 8'd224};

      #2;
      check("rst_oe", 64'(ifa.output_enable), 64'd0);
      check("rst_val", ifa.val, 64'd0);
      check("rst_size", ifa.size_of_bit, 64'd0);
      check("rst_busy", 64'(ifa.busy), 64'd0);
      check("rst_done", 64'(ifa.done), 64'd0);
      check("rst_b_oe", 64'(ifb.output_enable), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 6; i++) run_a(vecs[i]);

      // Four components with flush on the final emitted size.
      bv = '{64'd8, 64'd0, 64'd100, 64'h0aaa, 64'h0bbb, 64'h0ccc};
      bs = '{64'd5, 64'd3, 64'd8, 64'd16, 64'd16, 64'd16};
      bf = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1};
      @(negedge clock);
      ifb.start     = 1'b1;
      ifb.qscale    = 8'd100;
      ifb.comp_size = {16'h0ddd, 16'h0ccc, 16'h0bbb, 16'h0aaa};
      ifb.out_ready = 1'b1;
      @(negedge clock);
      ifb.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check("b_oe", 64'(ifb.output_enable), 64'd1);
         check("b_val", ifb.val, bv[k]);
         check("b_size", ifb.size_of_bit, bs[k]);
         check("b_flush", 64'(ifb.flush_bit), bf[k]);
      end
      @(negedge clock);
      check("b_done", 64'(ifb.done), 64'd1);
      check("b_done_oe", 64'(ifb.output_enable), 64'd0);
      ifb.out_ready = 1'b0;

      // Reset while the QS field is being held.
      @(negedge clock);
      ifa.start     = 1'b1;
      ifa.qscale    = 8'd50;
      ifa.comp_size = 48'h0001_0002_0003;
      ifa.out_ready = 1'b1;
      @(negedge clock);
      ifa.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clock);
         if (ifa.output_enable && ifa.size_of_bit == 64'd8) begin
            found = 1'b1;
            ifa.out_ready = 1'b0;
         end
      end
      check("qs_reached", 64'(found), 64'd1);
      check("qs_val", ifa.val, 64'd50);
      #2 reset = 1'b1;
      #1;
      check("async_oe", 64'(ifa.output_enable), 64'd0);
      check("async_val", ifa.val, 64'd0);
      check("async_size", ifa.size_of_bit, 64'd0);
      check("async_flush", 64'(ifa.flush_bit), 64'd0);
      check("async_busy", 64'(ifa.busy), 64'd0);
      check("async_done", 64'(ifa.done), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      ifa.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         check("post_rst_oe", 64'(ifa.output_enable), 64'd0);
         check("post_rst_busy", 64'(ifa.busy), 64'd0);
      end
      run_a(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/slice_header_gen.md
SLICE_HEADER_GEN -- requirements
Module: slice_header_gen

Interface
REQ-001 Parameter NUM_COMP, default 3, component count per slice (legal 2..4); the header carries NUM_COMP-1 size fields.
REQ-002 Parameter MAX_QSCALE, default 224, upper clamp for qscale.
REQ-003 Parameter FLUSH_AT_END, default 0; when 1, the last field is emitted with flush_bit=1.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to emit a header; sampled only in IDLE.
REQ-007 qscale  in  8  slice quantiser scale, captured on accepted start.
REQ-008 comp_size  in  NUM_COMP*16  packed coded sizes in bytes, component i at bits [16i+15:16i], captured on accepted start.
REQ-009 out_ready  in  1  bit-writer accepts the current field.
REQ-010 output_enable  out  1  field valid.
REQ-011 val  out  64  field value, zero-extended.
REQ-012 size_of_bit  out  64  field width in bits.
REQ-013 flush_bit  out  1  request that the bit-writer byte-align after this field.
REQ-014 busy  out  1  high from accepted start through the final accepted field.
REQ-015 done  out  1  one-cycle pulse in the cycle after the final field is accepted.

Function
REQ-016 States: IDLE, HSIZE, RSV, QS, CSIZE, DONE.
REQ-017 IDLE: start=1 captures qscale and comp_size, clears idx, moves to HSIZE, and asserts busy on the next cycle; start in any other state is ignored.
REQ-018 HSIZE field: val = 2+2*(NUM_COMP-1) header bytes (6 for NUM_COMP=3, 8 for 4), size_of_bit=5.
REQ-019 RSV field: val=0, size_of_bit=3.
REQ-020 QS field: val = qscale clamped to 1..MAX_QSCALE (0->1, >MAX_QSCALE->MAX_QSCALE), size_of_bit=8.
REQ-021 CSIZE field: val = captured comp_size[idx], size_of_bit=16, idx=0..NUM_COMP-2; the last component size is never emitted.
REQ-022 Each field is presented registered, with output_enable=1; val, size_of_bit and flush_bit are held stable until the cycle output_enable&&out_ready is true.
REQ-023 When a field is accepted, the next field is presented in the following cycle with no bubble; out_ready held high yields 3+(NUM_COMP-1) consecutive fields.
REQ-024 The state machine advances HSIZE->RSV->QS->CSIZE on acceptance; in CSIZE, idx increments per acceptance, and acceptance at idx=NUM_COMP-2 moves to DONE.
REQ-025 DONE: done=1 and busy=0 for exactly one cycle, output_enable=0, then IDLE; start is not accepted in DONE.
REQ-026 flush_bit=1 only on the last CSIZE field and only when FLUSH_AT_END=1; otherwise flush_bit=0.
REQ-027 When output_enable=0: val=0, size_of_bit=0, flush_bit=0.
REQ-028 First field is valid two cycles after the start edge (capture cycle, then present cycle).
REQ-029 Input changes on qscale/comp_size while busy do not affect the header in progress.

Reset
REQ-030 reset=1 forces IDLE, idx=0, captured registers=0, and output_enable, val, size_of_bit, flush_bit, busy and done all 0, immediately and independent of clock.
REQ-031 Reset mid-header aborts the header without any partial continuation; after release, the block waits for a new start.

Structure
REQ-032 A shared package holds the state enum, field widths (5/3/8/16), and the header-byte function of NUM_COMP.
REQ-033 Single module, no sub-modules; qscale clamp is a local function.

Verification
REQ-034 NUM_COMP=3, qscale=8, sizes {0x319,0x7c,0x50}, out_ready=1 -> fields (6,5),(0,3),(8,8),(0x319,16),(0x7c,16) on consecutive cycles, then done pulse.
REQ-035 NUM_COMP=4, FLUSH_AT_END=1 -> HSIZE val=8, three CSIZE fields, flush_bit=1 only on the third.
REQ-036 out_ready toggled randomly -> each field held stable until accepted, order unchanged, no dropped or duplicated field.
REQ-037 qscale=0 -> QS val=1; qscale=255 -> QS val=224.
REQ-038 start repeated while busy plus input changes mid-header -> ignored; output matches the first capture.
REQ-039 reset asserted during the QS field -> all outputs 0 asynchronously; the next start produces a complete header.
